// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline hazard control slice.
package mips_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [3:0] MULT_CYC  = 4'd5;
  localparam logic [3:0] DIV_CYC   = 4'd10;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_M   = 2'd1,
    FWD_W   = 2'd2
  } fwd_sel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Destination register and cycles-until-result for one pipeline stage.
  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{a3: 5'd0, tnew: 2'd0};

  // One stage further down the pipe the result is one cycle closer.
  function automatic stage_t age_stage(input stage_t s);
    stage_t r;
    r.a3   = s.a3;
    r.tnew = (s.tnew == 2'd0) ? 2'd0 : s.tnew - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Tracks the occupancy of the multi-cycle mult/div unit.
module md_busy_ctr
  import mips_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Next state: load latency on start, count down while busy, leave on the last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = is_div ? DIV_CYC : MULT_CYC;
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and counter registers; reset cancels any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: stage tracking, stall/flush control and E-stage forwarding.
module hazard_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] A1_D,
  input  logic [4:0] A2_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic [4:0] A3_D,
  input  logic [1:0] Tnew_D,
  input  logic       md_D,
  input  logic       md_div_D,
  input  logic       mdrd_D,
  input  logic       flush_req,
  output logic       PC_en,
  output logic       IFID_en,
  output logic       IDEX_clr,
  output logic       EXMEM_clr,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       md_busy
);

  logic [4:0] e_a1_q, e_a1_d;
  logic [4:0] e_a2_q, e_a2_d;
  stage_t     e_q, e_d;
  stage_t     m_q, m_d;
  stage_t     w_q, w_d;

  logic stall_rs, stall_rt, stall_md, stall;
  logic md_start;

  // A source stalls when a producer in E or M cannot deliver before the operand is needed.
  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input stage_t e, input stage_t m);
    logic hit_e, hit_m;
    hit_e = (src == e.a3) && (e.tnew > tuse);
    hit_m = (src == m.a3) && (m.tnew > tuse);
    return (tuse != TUSE_NONE) && (src != 5'd0) && (hit_e || hit_m);
  endfunction

  // M forwards only once its result exists; M is younger so it wins over W.
  function automatic logic [1:0] fwd_select(input logic [4:0] src, input stage_t m,
                                            input stage_t w);
    logic [1:0] sel;
    sel = FWD_REG;
    if ((src != 5'd0) && (src == m.a3) && (m.tnew == 2'd0)) begin
      sel = FWD_M;
    end else if ((src == w.a3) && (w.a3 != 5'd0)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  // Interlock and pipeline register controls, purely combinational on the current state.
  always_comb begin
    stall_rs  = src_hazard(A1_D, Tuse_rs_D, e_q, m_q);
    stall_rt  = src_hazard(A2_D, Tuse_rt_D, e_q, m_q);
    stall_md  = (md_D || mdrd_D) && md_busy;
    stall     = stall_rs || stall_rt || stall_md;
    PC_en     = !stall;
    IFID_en   = !stall;
    IDEX_clr  = stall || flush_req;
    EXMEM_clr = flush_req;
    fwd_rs_E  = fwd_select(e_a1_q, m_q, w_q);
    fwd_rt_E  = fwd_select(e_a2_q, m_q, w_q);
  end

  // Shadow pipe advance. A stall bubble keeps the stalled source numbers so the
  // W-stage forward is already visible in the cycle the interlock releases.
  always_comb begin
    w_d    = age_stage(m_q);
    m_d    = age_stage(e_q);
    e_a1_d = A1_D;
    e_a2_d = A2_D;
    e_d    = '{a3: A3_D, tnew: Tnew_D};
    if (flush_req) begin
      m_d    = STAGE_BUBBLE;
      e_d    = STAGE_BUBBLE;
      e_a1_d = 5'd0;
      e_a2_d = 5'd0;
    end else if (stall) begin
      e_d    = STAGE_BUBBLE;
    end
  end

  // Shadow stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_a1_q <= 5'd0;
      e_a2_q <= 5'd0;
      e_q    <= STAGE_BUBBLE;
      m_q    <= STAGE_BUBBLE;
      w_q    <= STAGE_BUBBLE;
    end else begin
      e_a1_q <= e_a1_d;
      e_a2_q <= e_a2_d;
      e_q    <= e_d;
      m_q    <= m_d;
      w_q    <= w_d;
    end
  end

  assign md_start = md_D && !stall && !flush_req;

  md_busy_ctr u_md_busy_ctr (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (md_div_D),
    .busy   (md_busy)
  );

endmodule
